// File: rtl/video_pkg.sv
// Shared video timing descriptors, standard modes and the pixel-repetition encoding.
package video_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    logic        pol;
  } video_timing_t;

  typedef struct packed {
    video_timing_t h;
    video_timing_t v;
  } video_mode_t;

  localparam video_mode_t SVGA_800x600_60 = '{
    h: '{active: 800, front: 40, sync: 128, back: 88, pol: 1'b1},
    v: '{active: 600, front: 1,  sync: 4,   back: 23, pol: 1'b1}
  };

  localparam video_mode_t VGA_640x480_60 = '{
    h: '{active: 640, front: 16, sync: 96, back: 48, pol: 1'b0},
    v: '{active: 480, front: 10, sync: 2,  back: 33, pol: 1'b0}
  };

  typedef enum logic [1:0] {
    SCALE_1X,
    SCALE_2X,
    SCALE_4X,
    SCALE_8X
  } scale_e;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX up-counter; wrap flags the increment that returns the count to zero.
module wrap_counter #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap  = inc && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = wrap ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, data enable, line/frame pulses and
// pixel coordinates scaled by a repetition factor that only changes between frames.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = SVGA_800x600_60.h.active,
  parameter int unsigned H_FRONT   = SVGA_800x600_60.h.front,
  parameter int unsigned H_SYNC    = SVGA_800x600_60.h.sync,
  parameter int unsigned H_BACK    = SVGA_800x600_60.h.back,
  parameter int unsigned V_ACTIVE  = SVGA_800x600_60.v.active,
  parameter int unsigned V_FRONT   = SVGA_800x600_60.v.front,
  parameter int unsigned V_SYNC    = SVGA_800x600_60.v.sync,
  parameter int unsigned V_BACK    = SVGA_800x600_60.v.back,
  parameter bit          HSYNC_POL = SVGA_800x600_60.h.pol,
  parameter bit          VSYNC_POL = SVGA_800x600_60.v.pol,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW       = $clog2(H_TOTAL),
  localparam int unsigned VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [1:0]    scale_sel,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          next_vertical,
  output logic          next_frame,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y
);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
    $error("video_timing_gen: every active/porch/sync parameter must be >= 1");
  end

  if ((H_ACTIVE >> 3) < 1 || (V_ACTIVE >> 3) < 1) begin : g_bad_active
    $error("video_timing_gen: active region must hold at least one 8x-scaled pixel");
  end

  // Region boundaries; all fit the counter width because each back porch is >= 1.
  localparam logic [HW-1:0] H_ACTIVE_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACTIVE_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_wrap, v_wrap, v_inc;

  assign v_inc = enable && h_wrap;

  wrap_counter #(
    .MAX(H_TOTAL),
    .W  (HW)
  ) u_hcnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (enable),
    .count  (hcnt),
    .wrap   (h_wrap)
  );

  wrap_counter #(
    .MAX(V_TOTAL),
    .W  (VW)
  ) u_vcnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (v_inc),
    .count  (vcnt),
    .wrap   (v_wrap)
  );

  // v_wrap fires only on the last pixel of the frame, so the scale never changes mid-frame.
  scale_e scale_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scale_q <= SCALE_1X;
    end else if (v_wrap) begin
      scale_q <= scale_e'(scale_sel);
    end
  end

  logic          h_active, v_active, h_sync_on, v_sync_on;
  logic          hsync_d, vsync_d, de_d, line_start, frame_start;
  logic [HW-1:0] x_d;
  logic [VW-1:0] y_d;

  always_comb begin
    h_active    = hcnt < H_ACTIVE_END;
    v_active    = vcnt < V_ACTIVE_END;
    h_sync_on   = (hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END);
    v_sync_on   = (vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END);
    hsync_d     = HSYNC_POL ? h_sync_on : !h_sync_on;
    vsync_d     = VSYNC_POL ? v_sync_on : !v_sync_on;
    de_d        = h_active && v_active;
    line_start  = hcnt == '0;
    frame_start = line_start && (vcnt == '0);
    x_d         = de_d ? (hcnt >> scale_q) : '0;
    y_d         = de_d ? (vcnt >> scale_q) : '0;
  end

  logic          hsync_q, vsync_q, hblank_q, vblank_q, de_q, nv_q, nf_q;
  logic [HW-1:0] x_q;
  logic [VW-1:0] y_q;

  // While paused, sync/blank keep their last level; enable-qualified outputs drop to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      nv_q     <= 1'b0;
      nf_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (enable) begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblank_q <= !h_active;
      vblank_q <= !v_active;
      de_q     <= de_d;
      nv_q     <= line_start;
      nf_q     <= frame_start;
      x_q      <= x_d;
      y_q      <= y_d;
    end else begin
      de_q     <= 1'b0;
      nv_q     <= 1'b0;
      nf_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end
  end

  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign hblank        = hblank_q;
  assign vblank        = vblank_q;
  assign de            = de_q;
  assign next_vertical = nv_q;
  assign next_frame    = nf_q;
  assign x             = x_q;
  assign y             = y_q;

endmodule
